// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Debounces an active-low push-button pin into a clean level
//               plus one-cycle press/release pulses and a press counter.
// Revision    : 1.0
// ============================================================================

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 17,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_n,
  output logic               btn_db_n,
  output logic               press,
  // "release" is a reserved word in SystemVerilog, hence the suffix.
  output logic               release_pulse,
  output logic [COUNT_W-1:0] press_count
);

  localparam logic [1:0] c_rel   = 2'd0;
  localparam logic [1:0] c_chk_p = 2'd1;
  localparam logic [1:0] c_prs   = 2'd2;
  localparam logic [1:0] c_chk_r = 2'd3;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_db_n;
  logic               r_press;
  logic               r_release;
  logic [COUNT_W-1:0] r_press_count;

  // Synchronizer idles at "released" so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_rel;
      r_cnt         <= '0;
      r_db_n        <= 1'b1;
      r_press       <= 1'b0;
      r_release     <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        c_rel: begin
          if (!r_sync2) begin
            r_state <= c_chk_p;
            r_cnt   <= '0;
          end
        end
        c_chk_p: begin
          if (r_sync2) begin
            r_state <= c_rel;
            r_cnt   <= '0;
          end else if (r_cnt == c_cnt_last) begin
            r_state       <= c_prs;
            r_cnt         <= '0;
            r_db_n        <= 1'b0;
            r_press       <= 1'b1;
            r_press_count <= r_press_count + COUNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        c_prs: begin
          if (r_sync2) begin
            r_state <= c_chk_r;
            r_cnt   <= '0;
          end
        end
        c_chk_r: begin
          if (!r_sync2) begin
            r_state <= c_prs;
            r_cnt   <= '0;
          end else if (r_cnt == c_cnt_last) begin
            r_state   <= c_rel;
            r_cnt     <= '0;
            r_db_n    <= 1'b1;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= c_rel;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign btn_db_n      = r_db_n;
  assign press         = r_press;
  assign release_pulse = r_release;
  assign press_count   = r_press_count;

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce
// Description : Self-checking bench for button_debounce (DEBOUNCE_CYCLES = 4).
// Revision    : 1.0
// ============================================================================

module tb_button_debounce;

  localparam int DC = 4;

  logic       clk;
  logic       rst;
  logic       btn_n;
  logic       btn_db_n;
  logic       press;
  logic       release_pulse;
  logic [7:0] press_count;

  int n_total;
  int n_pass;

  // Reference: the level flips once DC+1 consecutive FSM-visible samples
  // (the pin two edges late) disagree with the current debounced level.
  logic m_pipe0, m_pipe1;
  logic m_db, m_press, m_rel;
  int   m_run, m_cnt;

  typedef struct {
    logic btn;
    logic db;
    logic prs;
    logic rel;
    int   cnt;
  } vec_t;

  vec_t tbl[16];

  button_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(3),
    .COUNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .btn_db_n(btn_db_n),
    .press(press),
    .release_pulse(release_pulse),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pipe0 = 1'b1;
    m_pipe1 = 1'b1;
    m_db    = 1'b1;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_run   = 0;
    m_cnt   = 0;
  endtask

  // One clock edge; returns #1 after the edge with the model updated.
  task automatic step();
    logic smp;
    logic s_obs;
    smp = btn_n;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      s_obs   = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = smp;
      m_press = 1'b0;
      m_rel   = 1'b0;
      if (s_obs != m_db) begin
        m_run++;
        if (m_run == DC + 1) begin
          m_db  = s_obs;
          m_run = 0;
          if (!m_db) begin
            m_press = 1'b1;
            m_cnt   = (m_cnt + 1) % 256;
          end else begin
            m_rel = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".db"},    int'(btn_db_n),      int'(m_db));
    check({tag, ".press"}, int'(press),         int'(m_press));
    check({tag, ".rel"},   int'(release_pulse), int'(m_rel));
    check({tag, ".cnt"},   int'(press_count),   m_cnt);
  endtask

  task automatic check_idle(input string tag, input int cnt);
    check({tag, ".db"},    int'(btn_db_n),      1);
    check({tag, ".press"}, int'(press),         0);
    check({tag, ".rel"},   int'(release_pulse), 0);
    check({tag, ".cnt"},   int'(press_count),   cnt);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b0;
    btn_n   = 1'b1;
    model_reset();

    for (int i = 0; i < 16; i++) begin
      tbl[i].btn = (i < 8) ? 1'b0 : 1'b1;
      tbl[i].db  = (i < 6 || i >= 14) ? 1'b1 : 1'b0;
      tbl[i].prs = (i == 6) ? 1'b1 : 1'b0;
      tbl[i].rel = (i == 14) ? 1'b1 : 1'b0;
      tbl[i].cnt = (i < 6) ? 0 : 1;
    end

    // Reset asserted before any clock edge must act immediately.
    #3;
    rst = 1'b1;
    #1;
    check_idle("rst_async", 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("rst_hold", 0);
    end
    #2;
    rst = 1'b0;
    model_reset();
    repeat (3) step();

    // Bounce: low 2, high 1, never DC+1 stable samples.
    for (int i = 0; i < 30; i++) begin
      btn_n = (i % 3 == 2) ? 1'b1 : 1'b0;
      step();
      check_idle("bounce", 0);
    end
    btn_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_idle("bounce_settle", 0);
    end

    // Clean press then clean release, one row per edge.
    for (int i = 0; i < 16; i++) begin
      btn_n = tbl[i].btn;
      step();
      check($sformatf("tbl%0d.db", i),    int'(btn_db_n),      int'(tbl[i].db));
      check($sformatf("tbl%0d.press", i), int'(press),         int'(tbl[i].prs));
      check($sformatf("tbl%0d.rel", i),   int'(release_pulse), int'(tbl[i].rel));
      check($sformatf("tbl%0d.cnt", i),   int'(press_count),   tbl[i].cnt);
    end

    // Counter wrap.
    pulse_reset();
    for (int i = 0; i < 255; i++) begin
      btn_n = 1'b0;
      repeat (10) step();
      btn_n = 1'b1;
      repeat (10) step();
    end
    check("wrap_255", int'(press_count), 255);
    btn_n = 1'b0;
    repeat (10) step();
    check("wrap_0", int'(press_count), 0);
    check("wrap_db", int'(btn_db_n), 0);

    // Build a non-zero count, then reset in CHK_P at counter = 2.
    btn_n = 1'b1;
    repeat (10) step();
    btn_n = 1'b0;
    repeat (10) step();
    btn_n = 1'b1;
    repeat (10) step();
    check("pre_mid_cnt", int'(press_count), 1);
    btn_n = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    model_reset();
    check_idle("rst_mid", 0);
    #2;
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("post_rst_e%0d.press", i), int'(press), (i == 7) ? 1 : 0);
      check_model($sformatf("post_rst_e%0d", i));
    end

    // Randomized holds against the reference model, with rare async resets.
    pulse_reset();
    btn_n = 1'b1;
    for (int i = 0; i < 2000; ) begin
      int hold;
      hold  = $urandom_range(1, 9);
      btn_n = ~btn_n;
      for (int j = 0; j < hold && i < 2000; j++, i++) begin
        step();
        check_model("rand");
        if ($urandom_range(0, 299) == 0) begin
          pulse_reset();
          #1;
          check_model("rand_rst");
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_debounce.md
# button_debounce

Debounces one raw, asynchronous, active-low push-button pin on the Elbert V2 board and presents a clean, synchronous level plus edge events. It sits directly upstream of the inverter stage (`myNot`). That stage consumes `btn_db_n` and produces the active-high "pressed" signal that drives LEDs and control logic. It also supplies one-cycle press and release pulses and a wrapping press counter for the display logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 120000. Number of consecutive stable samples required before a level change is accepted (10 ms at 12 MHz). Must be ≥ 1.
- `CNT_W`, default 17. Width of the debounce counter. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `COUNT_W`, default 8. Width of `press_count`.

Ports:
- `clk`, input, 1 bit. Single system clock; 12 MHz on board.
- `rst`, input, 1 bit. Asynchronous, active-high reset.
- `btn_n`, input, 1 bit. Raw pin, asynchronous to `clk`. 0 = pressed, 1 = released.
- `btn_db_n`, output, 1 bit. Debounced level, same polarity as `btn_n`. Registered.
- `press`, output, 1 bit. One-cycle pulse when `btn_db_n` goes 1→0. Registered.
- `release`, output, 1 bit. One-cycle pulse when `btn_db_n` goes 0→1. Registered.
- `press_count`, output, `COUNT_W` bits. Number of accepted presses, modulo 2^COUNT_W.

## Operation
Synchronizer:
- Two-flop synchronizer on `btn_n`, producing `s`.
- Both flops reset to 1 (released).

FSM, four states:
- **REL**, the reset state. `btn_db_n` = 1.
  - If `s` = 0: go to CHK_P and clear the counter to 0.
- **CHK_P**:
  - If `s` = 1 (bounce): go back to REL, clear the counter, leave the outputs unchanged.
  - If `s` = 0 and counter = DEBOUNCE_CYCLES−1: go to PRS. Set `btn_db_n` to 0, set `press` to 1, and increment `press_count`.
  - Otherwise: increment the counter.
- **PRS**. `btn_db_n` = 0.
  - If `s` = 1: go to CHK_R and clear the counter to 0.
- **CHK_R**. Mirror of CHK_P:
  - If `s` = 0: go back to PRS.
  - On an accepted release: go to REL, set `btn_db_n` to 1, and set `release` to 1. `press_count` is unchanged.

Output and counter rules:
- `press` and `release` are 0 in every cycle other than their transition cycle. They are never both 1.
- `press_count` wraps from 2^COUNT_W−1 to 0 with no saturation and no flag.
- The debounce counter only counts in a CHK state, and it never exceeds DEBOUNCE_CYCLES−1.

Reset values (applied asynchronously the moment `rst` rises, whatever the current state):
- `btn_db_n` = 1, `press` = 0, `release` = 0, `press_count` = 0.
- FSM = REL, counter = 0, synchronizer flops = 1.

Other rules:
- Reset is allowed at any point, including mid-CHK and during a pulse cycle. No partial count survives it.
- After `rst` deasserts with the pin held low, a full debounce interval is required before `press`.
- No output depends combinationally on `btn_n`.

## Timing
Let edge 1 be the first rising edge of `clk` that samples `btn_n` at its new level. Provided the pin is held stable from then on:
- Edge 2: `s` takes the new level.
- Edge 3: the FSM enters CHK_P (or CHK_R) with counter = 0.
- Edge DEBOUNCE_CYCLES+2: the counter reaches DEBOUNCE_CYCLES−1.
- Edge DEBOUNCE_CYCLES+3: `btn_db_n` changes and `press` (or `release`) rises.
- Edge DEBOUNCE_CYCLES+4: the pulse falls.

Latency is therefore exactly DEBOUNCE_CYCLES+3 cycles.

Bounce:
- Any sample of the old level in a CHK state restarts the whole interval from the next change of `s`.
- Glitches shorter than one clock period may be missed entirely. This is acceptable.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and COUNT_W = 8.
1. **Reset:** assert `rst` with `btn_n` = 1 and hold for 5 cycles → `btn_db_n` = 1, `press` = 0, `release` = 0, `press_count` = 0 throughout, including immediately at assertion with no clock edge.
2. **Clean press:** drive `btn_n` from 1 to 0, first sampled at edge 1, then hold → `btn_db_n` = 0 and `press` = 1 at edge 7, `press` = 0 at edge 8, `press_count` = 1, `release` = 0 throughout.
3. **Bounce rejection:** starting from REL, toggle `btn_n` with the pattern low 2 cycles, high 1 cycle, for 30 cycles, then hold 1 → `btn_db_n` stays 1, no pulses, `press_count` = 0.
4. **Clean release after press:** after scenario 2, drive `btn_n` to 1, sampled at edge 1 → `btn_db_n` = 1 and `release` = 1 at edge 7, `press_count` still 1.
5. **Counter wrap:** perform 255 clean press/release pairs → `press_count` = 255. Perform one more press → `press_count` = 0.
6. **Reset mid-operation:** with `btn_n` held 0, assert `rst` asynchronously while in CHK_P at counter = 2 → outputs go to 1/0/0/0 immediately. Deassert `rst` with `btn_n` still 0 → `press` rises exactly 7 edges after the first post-reset edge, not earlier.
